// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with ready-based memory waits, bus timeout and instret.
// Optional macro CTRL_TRAP_EN adds a sticky TRAP state and a trap output for SYSTEM/unknown opcodes.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             mem_write,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             alu_src_a,
    output logic             alu_src_b,
    output logic [1:0]       alu_op,
    output logic             busy,
    output logic             mem_err,
    output logic [CNT_W-1:0] instret,
`ifdef CTRL_TRAP_EN
    output logic             trap,
`endif
    output logic [2:0]       dbg_state
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   instret_q, instret_d;
    logic               retire;
    logic               timed_out;

    assign timed_out = (wait_q == WAIT_W'(MEM_TIMEOUT));

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        retire    = 1'b0;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 2'b00;
        reg_write = 1'b0;
        wb_sel    = 2'b00;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        alu_op    = 2'b00;
        mem_err   = 1'b0;
        busy      = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                // Ready is checked before the timeout so a last-moment response is accepted.
                if (imem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    wait_d   = '0;
                    state_d  = S_DECODE;
                end else if (timed_out) begin
                    mem_err = 1'b1;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                state_d = S_FETCH;
                retire  = 1'b1;
                case (opcode)
                    OP_R: begin
                        alu_op  = 2'b10;
                        state_d = S_WB;
                        retire  = 1'b0;
                    end
                    OP_I: begin
                        alu_op    = 2'b10;
                        alu_src_b = 1'b1;
                        state_d   = S_WB;
                        retire    = 1'b0;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_b = 1'b1;
                        state_d   = S_MEM;
                        retire    = 1'b0;
                    end
                    OP_BRANCH: begin
                        alu_op   = 2'b01;
                        pc_write = branch_taken;
                        pc_src   = branch_taken ? 2'b01 : 2'b00;
                    end
                    OP_JAL: begin
                        pc_write  = 1'b1;
                        pc_src    = 2'b01;
                        reg_write = 1'b1;
                        wb_sel    = 2'b10;
                    end
                    OP_JALR: begin
                        pc_write  = 1'b1;
                        pc_src    = 2'b10;
                        reg_write = 1'b1;
                        wb_sel    = 2'b10;
                    end
                    OP_LUI: begin
                        reg_write = 1'b1;
                        wb_sel    = 2'b11;
                    end
                    OP_AUIPC: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 1'b1;
                        state_d   = S_WB;
                        retire    = 1'b0;
                    end
                    default: begin
`ifdef CTRL_TRAP_EN
                        state_d = S_TRAP;
                        retire  = 1'b0;
`endif
                    end
                endcase
            end
            S_MEM: begin
                dmem_req  = 1'b1;
                mem_write = (opcode == OP_STORE);
                if (dmem_ready) begin
                    wait_d = '0;
                    if (opcode == OP_STORE) begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timed_out) begin
                    // Abort: drop the access and refetch without retiring.
                    mem_err = 1'b1;
                    wait_d  = '0;
                    state_d = S_FETCH;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                wb_sel    = (opcode == OP_LOAD) ? 2'b01 : 2'b00;
                state_d   = S_FETCH;
                retire    = 1'b1;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase

        instret_d = retire ? instret_q + 1'b1 : instret_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
        end
    end

    assign instret   = instret_q;
    assign dbg_state = state_q;
`ifdef CTRL_TRAP_EN
    assign trap = (state_q == S_TRAP);
`endif

endmodule
